// File: rtl/bw_seq_multiplier.sv
// Sequential Baugh-Wooley multiplier: one partial-product row per cycle,
// signed or unsigned operands selected per operation, valid/ready on both sides.
module bw_seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [PW-1:0] CORR = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nx;
  logic [WIDTH-1:0]  a_cap, a_cap_nx;
  logic [WIDTH-1:0]  b_cap, b_cap_nx;
  logic              sgn_cap, sgn_cap_nx;
  logic [PW-1:0]     acc, acc_nx;
  logic [CW-1:0]     row_cnt, row_cnt_nx;
  logic [PW-1:0]     p_nx;
  logic              in_ready_nx;
  logic              out_valid_nx;

  logic [WIDTH-1:0]  pp;
  logic              last_row;
  logic              b_bit;
  logic [PW-1:0]     row_sum;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_cap     <= '0;
      b_cap     <= '0;
      sgn_cap   <= 1'b0;
      acc       <= '0;
      row_cnt   <= '0;
      p         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      a_cap     <= a_cap_nx;
      b_cap     <= b_cap_nx;
      sgn_cap   <= sgn_cap_nx;
      acc       <= acc_nx;
      row_cnt   <= row_cnt_nx;
      p         <= p_nx;
      in_ready  <= in_ready_nx;
      out_valid <= out_valid_nx;
    end
  end

  // Next-state, row generation and accumulation
  always_comb begin
    state_nx   = state;
    a_cap_nx   = a_cap;
    b_cap_nx   = b_cap;
    sgn_cap_nx = sgn_cap;
    acc_nx     = acc;
    row_cnt_nx = row_cnt;
    p_nx       = p;
    pp         = '0;

    last_row = (row_cnt == CW'(WIDTH - 1));
    b_bit    = b_cap[row_cnt];

    // Sign-bit cross terms are inverted; the sign*sign term is not.
    for (int j = 0; j < int'(WIDTH); j++) begin
      pp[j] = a_cap[j] & b_bit;
      if (sgn_cap && ((j == int'(WIDTH) - 1) != last_row)) begin
        pp[j] = ~pp[j];
      end
    end

    row_sum = acc + (PW'(pp) << row_cnt) + ((sgn_cap && last_row) ? CORR : '0);

    case (state)
      IDLE: begin
        if (in_valid) begin
          a_cap_nx   = a;
          b_cap_nx   = b;
          sgn_cap_nx = is_signed;
          acc_nx     = '0;
          row_cnt_nx = '0;
          state_nx   = BUSY;
        end
      end
      BUSY: begin
        acc_nx     = row_sum;
        row_cnt_nx = row_cnt + CW'(1);
        if (last_row) begin
          p_nx     = row_sum;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    in_ready_nx  = (state_nx == IDLE);
    out_valid_nx = (state_nx == DONE);
  end

endmodule
